// File: rtl/trap_step_scheduler.sv
// rtl/trap_step_scheduler.sv - per-frame, level-paced, phase-staggered step pulses for trap movers
module trap_step_scheduler #(
  parameter int NUM_TRAPS    = 4,
  parameter int LEVEL_W      = 3,
  parameter int BASE_PERIOD  = 4,
  parameter int MIN_PERIOD   = 1,
  parameter int GRACE_FRAMES = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 reset_level,
  input  logic                 pause,
  input  logic [LEVEL_W-1:0]   level,
  input  logic [NUM_TRAPS-1:0] trap_enable,
  output logic [NUM_TRAPS-1:0] step,
  output logic                 grace,
  output logic [3:0]           period
);

  typedef enum logic [0:0] {
    ST_GRACE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           gcnt_q, gcnt_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [3:0]           period_q, period_d;
  logic [NUM_TRAPS-1:0] step_q, step_d;
  logic                 grace_q, grace_d;
  logic                 sof_q;
  logic                 sof_edge;
  logic [NUM_TRAPS-1:0] phase_hit;

  // Frames per step for a level: BASE - level, floored at MIN without wrapping below zero.
  function automatic logic [3:0] calc_period(input logic [LEVEL_W-1:0] lv);
    if (32'(lv) >= 32'(BASE_PERIOD - MIN_PERIOD)) begin
      return 4'(MIN_PERIOD);
    end
    return 4'(32'(BASE_PERIOD) - 32'(lv));
  endfunction

  // A held frame strobe counts once, so a step can never last two cycles.
  assign sof_edge = startOfFrame & ~sof_q;

  // Trap i owns phase (i mod period); traps beyond the period share earlier phases.
  always_comb begin
    phase_hit = '0;
    for (int i = 0; i < NUM_TRAPS; i++) begin
      phase_hit[i] = (fcnt_q == 4'(i % int'(period_q)));
    end
  end

  // Next-state and next-output logic: level restart first, then pause, then frame tick.
  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    fcnt_d   = fcnt_q;
    period_d = period_q;
    step_d   = '0;

    if (reset_level) begin
      state_d  = ST_GRACE;
      gcnt_d   = 8'(GRACE_FRAMES);
      fcnt_d   = 4'd0;
      period_d = calc_period(level);
    end else if (!pause && sof_edge) begin
      case (state_q)
        ST_GRACE: begin
          if (gcnt_q == 8'd1) begin
            gcnt_d  = 8'd0;
            fcnt_d  = 4'd0;
            state_d = ST_RUN;
          end else begin
            gcnt_d = gcnt_q - 8'd1;
          end
        end
        ST_RUN: begin
          step_d = phase_hit & trap_enable;
          // Level changes only take effect on the wrap so a step cycle is never cut short.
          if (fcnt_q == period_q - 4'd1) begin
            fcnt_d   = 4'd0;
            period_d = calc_period(level);
          end else begin
            fcnt_d = fcnt_q + 4'd1;
          end
        end
        default: state_d = ST_GRACE;
      endcase
    end

    grace_d = (state_d == ST_GRACE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_GRACE;
      gcnt_q   <= 8'(GRACE_FRAMES);
      fcnt_q   <= 4'd0;
      period_q <= 4'(BASE_PERIOD);
      step_q   <= '0;
      grace_q  <= 1'b1;
      sof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      fcnt_q   <= fcnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      grace_q  <= grace_d;
      sof_q    <= startOfFrame;
    end
  end

  assign step   = step_q;
  assign grace  = grace_q;
  assign period = period_q;

endmodule

// File: tb/tb_trap_step_scheduler.sv
// tb/tb_trap_step_scheduler.sv - directed scoreboard bench for trap_step_scheduler
module tb_trap_step_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       reset_level = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] level = 3'd0;
  logic [3:0] trap_enable = 4'b1111;
  logic [3:0] step;
  logic       grace;
  logic [3:0] period;

  int n_total = 0;
  int n_pass  = 0;
  logic [3:0] exp_q[$];

  trap_step_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .reset_level  (reset_level),
    .pause        (pause),
    .level        (level),
    .trap_enable  (trap_enable),
    .step         (step),
    .grace        (grace),
    .period       (period)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_chk(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, step);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(step), 32'(e));
    end
  endtask

  // One frame strobe: expected step vector goes on the scoreboard as SOF is driven,
  // and is compared one cycle later; the following cycle step must be low again.
  task automatic sof(input logic [3:0] exp, input logic p_after);
    startOfFrame = 1'b1;
    exp_q.push_back(exp);
    tick();
    startOfFrame = 1'b0;
    pause = p_after;
    pop_chk("step");
    tick();
    chk("step_gap", 32'(step), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_grace", 32'(grace), 32'd1);
    chk("rst_period", 32'(period), 32'd4);

    // T1: grace window of 60 frames, no steps
    for (int k = 1; k <= 60; k++) begin
      sof(4'b0000, 1'b0);
      chk($sformatf("t1_grace_%0d", k), 32'(grace), (k < 60) ? 32'd1 : 32'd0);
    end

    // T2: period 4 rotation
    sof(4'b0001, 1'b0); sof(4'b0010, 1'b0); sof(4'b0100, 1'b0); sof(4'b1000, 1'b0);
    sof(4'b0001, 1'b0); sof(4'b0010, 1'b0); sof(4'b0100, 1'b0); sof(4'b1000, 1'b0);
    chk("t2_period", 32'(period), 32'd4);

    // T3: level 5 saturates to period 1, applied only at the wrap
    level = 3'd5;
    sof(4'b0001, 1'b0);
    chk("t3_no_mid_change", 32'(period), 32'd4);
    sof(4'b0010, 1'b0); sof(4'b0100, 1'b0); sof(4'b1000, 1'b0);
    chk("t3_period1", 32'(period), 32'd1);
    sof(4'b1111, 1'b0); sof(4'b1111, 1'b0); sof(4'b1111, 1'b0);
    level = 3'd2;
    sof(4'b1111, 1'b0);
    chk("t3_period2", 32'(period), 32'd2);
    sof(4'b0101, 1'b0); sof(4'b1010, 1'b0); sof(4'b0101, 1'b0); sof(4'b1010, 1'b0);

    // T4: back to period 4, pause at fcnt=2; the step pending when pause rises completes
    level = 3'd0;
    sof(4'b0101, 1'b0); sof(4'b1010, 1'b0);
    chk("t4_period4", 32'(period), 32'd4);
    sof(4'b0001, 1'b0);
    sof(4'b0010, 1'b1);
    for (int k = 0; k < 10; k++) sof(4'b0000, 1'b1);
    chk("t4_grace_paused", 32'(grace), 32'd0);
    pause = 1'b0;
    tick();
    sof(4'b0100, 1'b0);

    // T5: reset_level coincident with SOF wins; grace restarts with full count
    level = 3'd1;
    reset_level = 1'b1;
    startOfFrame = 1'b1;
    exp_q.push_back(4'b0000);
    tick();
    reset_level = 1'b0;
    startOfFrame = 1'b0;
    pop_chk("t5_step");
    chk("t5_grace", 32'(grace), 32'd1);
    chk("t5_period", 32'(period), 32'd3);
    tick();
    for (int k = 1; k <= 60; k++) begin
      sof(4'b0000, 1'b0);
      if (k >= 59) chk($sformatf("t5_grace_%0d", k), 32'(grace), (k < 60) ? 32'd1 : 32'd0);
    end

    // T6: masking trap 2 while phases keep advancing; period 3 first, then 4
    level = 3'd0;
    trap_enable = 4'b1011;
    sof(4'b1001, 1'b0); sof(4'b0010, 1'b0); sof(4'b0000, 1'b0);
    chk("t6_period4", 32'(period), 32'd4);
    sof(4'b0001, 1'b0); sof(4'b0010, 1'b0); sof(4'b0000, 1'b0); sof(4'b1000, 1'b0);
    trap_enable = 4'b1111;
    sof(4'b0001, 1'b0); sof(4'b0010, 1'b0); sof(4'b0100, 1'b0); sof(4'b1000, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
